approx_mul_pipe: RTL
====================

Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 half-adder-array approximate multiplier.
- Builds N/2 row-pair HA arrays from the unsigned partial products.
- Each HA cell runs in a runtime-selectable approximation mode held in a config register file.
- Reduces the arrays to a 2N-bit product behind valid/ready handshakes, and accumulates error statistics against the exact product for on-line MAE characterisation.

Parameters:
N, 8, operand width; even, >= 4
ACC_W, 32, width of absolute-error accumulator
CNT_W, 16, width of sample counter
(derived) CELLS = (N/2)*(N-1); AW = clog2(CELLS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  operand accepted when in_valid & in_ready
x  in  N  multiplicand
y  in  N  multiplier
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
prod  out  2N  approximate product
cfg_wr  in  1  write one cell mode
cfg_addr  in  AW  cell index = pair*(N-1)+cell
cfg_mode  in  2  mode code
stat_clr  in  1  synchronous clear of statistics
err_acc  out  ACC_W  saturating sum of |exact - prod|
err_cnt  out  CNT_W  saturating count of products delivered

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Array construction, pair k = 0..N/2-1 (rows x[2k], x[2k+1]):
- t[0] = y[0]&x[2k].
- For cell i = 0..N-2: a = y[i+1]&x[2k], b = y[i]&x[2k+1].
- Cell i sum goes to t[i+1], weight 2k+i+1.
- Cell i carry goes to b[i], weight 2k+i+2, for i <= N-3. The carry of cell N-2 goes to t[N].
- b[N-2] = y[N-1]&x[2k+1].
- Pair value = (t << 2k) + (b << (2k+2)). prod = sum over all pairs, truncated to 2N bits.

Cell modes:
- 00 exact HA: sum = a^b, carry = a&b.
- 01 OR-sum: sum = a|b, carry = 0.
- 10 A-carry: sum = 0, carry = a.
- 11 truncate: sum = 0, carry = 0.

Config register file:
- Reset: all cells 00, so prod is exact.
- cfg_wr with cfg_addr >= CELLS is ignored.
- A write in cycle c affects operands accepted in cycle c+1 onward. An operand accepted in cycle c uses the old mode.

Pipeline:
- S1 registers the HA array bits and the exact product x*y.
- S2 registers the reduced prod and exact product. Latency is 2 cycles when not stalled.
- Each stage holds a valid bit. in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready.
- Bubbles collapse. Throughput is 1 per cycle with out_ready held high.
- prod and out_valid are stable while out_valid & !out_ready.

Statistics:
- On each output handshake (out_valid & out_ready): err_acc += |exact - prod| and err_cnt += 1.
- Both saturate at all-ones.
- stat_clr zeroes both. If stat_clr coincides with a handshake, clear wins and that sample is dropped.

Reset (mid-operation included):
- s1_valid, s2_valid, out_valid = 0; prod = 0; err_acc = 0; err_cnt = 0; all modes = 00.
- Reset forces in_ready = 1 one cycle after rst_n deasserts.
- Transactions in flight are discarded.

Test Plan:
- Reset, modes default; x=255, y=255, out_ready=1 -> prod=65025 two cycles after accept; err_acc=0, err_cnt=1.
- cfg_wr addr=0 mode=01 (pair0 cell0 OR-sum); x=3, y=3 -> prod=7 (exact 9); err_acc=2.
- cfg_wr addr=1 mode=10 (pair0 cell1 A-carry); x=1, y=4 -> prod=8 (exact 4); err_acc += 4.
- Back-to-back stream of 4 operands, out_ready low for 3 cycles mid-stream:
  - in_ready drops once both stages are full;
  - no product is lost or duplicated;
  - order is preserved;
  - prod is held stable while stalled.
- cfg_wr and in_valid handshake in the same cycle -> that operand uses the old mode; the next operand uses the new mode. cfg_addr=CELLS -> no mode change.
- stat_clr together with a handshake -> err_acc=0, err_cnt=0. Assert rst_n=0 with both stages full -> out_valid=0 immediately, no stale product after release.

Source files
------------

// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul_pipe
// Description : Pipelined NxN approximate multiplier built from row-pair
//               half-adder arrays with per-cell runtime mode, plus on-line
//               absolute-error statistics against the exact product.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mul_pipe #(
    parameter  int N     = 8,
    parameter  int ACC_W = 32,
    parameter  int CNT_W = 16,
    localparam int CELLS = (N / 2) * (N - 1),
    localparam int AW    = $clog2(CELLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       x,
    input  logic [N-1:0]       y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     prod,
    input  logic               cfg_wr,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [1:0]         cfg_mode,
    input  logic               stat_clr,
    output logic [ACC_W-1:0]   err_acc,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int c_PAIRS = N / 2;
    localparam int c_SW    = ((ACC_W > 2 * N) ? ACC_W : 2 * N) + 1;

    logic [1:0]       r_mode [CELLS];
    logic [N:0]       w_t    [c_PAIRS];
    logic [N-2:0]     w_b    [c_PAIRS];
    logic [2*N-1:0]   w_exact;

    logic             r_s1_valid;
    logic [N:0]       r_s1_t [c_PAIRS];
    logic [N-2:0]     r_s1_b [c_PAIRS];
    logic [2*N-1:0]   r_s1_exact;
    logic [2*N-1:0]   w_prod;

    logic             r_s2_valid;
    logic [2*N-1:0]   r_s2_prod;
    logic [2*N-1:0]   r_s2_exact;

    logic             w_s1_adv;
    logic             w_hs;
    logic [2*N-1:0]   w_err;
    logic [c_SW-1:0]  w_acc_sum;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    assign w_exact = (2 * N)'(x) * (2 * N)'(y);

    // Each pair folds rows x[2k] and x[2k+1] through a line of N-1 HA cells.
    generate
        for (genvar k = 0; k < c_PAIRS; k++) begin : g_pair
            logic [N:0]   w_tp;
            logic [N-2:0] w_bp;
            logic         w_a, w_bb, w_s, w_c;

            always_comb begin
                w_tp    = '0;
                w_bp    = '0;
                w_a     = 1'b0;
                w_bb    = 1'b0;
                w_s     = 1'b0;
                w_c     = 1'b0;
                w_tp[0] = y[0] & x[2*k];
                for (int i = 0; i < N - 1; i++) begin
                    w_a  = y[i+1] & x[2*k];
                    w_bb = y[i] & x[2*k+1];
                    case (r_mode[k*(N-1)+i])
                        2'b00:   begin w_s = w_a ^ w_bb; w_c = w_a & w_bb; end
                        2'b01:   begin w_s = w_a | w_bb; w_c = 1'b0;       end
                        2'b10:   begin w_s = 1'b0;       w_c = w_a;        end
                        default: begin w_s = 1'b0;       w_c = 1'b0;       end
                    endcase
                    w_tp[i+1] = w_s;
                    if (i == N - 2) w_tp[N] = w_c;
                    else            w_bp[i] = w_c;
                end
                w_bp[N-2] = y[N-1] & x[2*k+1];
            end

            assign w_t[k] = w_tp;
            assign w_b[k] = w_bp;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < CELLS; j++) r_mode[j] <= 2'b00;
        end else if (cfg_wr && (32'(cfg_addr) < CELLS)) begin
            r_mode[cfg_addr] <= cfg_mode;
        end
    end

    assign w_s1_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_exact <= '0;
            for (int k = 0; k < c_PAIRS; k++) begin
                r_s1_t[k] <= '0;
                r_s1_b[k] <= '0;
            end
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                r_s1_exact <= w_exact;
                for (int k = 0; k < c_PAIRS; k++) begin
                    r_s1_t[k] <= w_t[k];
                    r_s1_b[k] <= w_b[k];
                end
            end
        end
    end

    // Modulo-2^2N accumulation gives the required truncation for free.
    always_comb begin
        w_prod = '0;
        for (int k = 0; k < c_PAIRS; k++) begin
            w_prod = w_prod + ((2 * N)'(r_s1_t[k]) << (2 * k))
                            + ((2 * N)'(r_s1_b[k]) << (2 * k + 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_exact <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod  <= w_prod;
                r_s2_exact <= r_s1_exact;
            end
        end
    end

    assign w_hs      = r_s2_valid && out_ready;
    assign w_err     = (r_s2_exact >= r_s2_prod) ? (r_s2_exact - r_s2_prod)
                                                 : (r_s2_prod - r_s2_exact);
    assign w_acc_sum = c_SW'(r_acc) + c_SW'(w_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (stat_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_hs) begin
            r_acc <= (w_acc_sum > c_SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}}
                                                        : w_acc_sum[ACC_W-1:0];
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign prod      = r_s2_prod;
    assign err_acc   = r_acc;
    assign err_cnt   = r_cnt;

endmodule
`default_nettype wire
